// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder bank: quadrature states, direction,
// transition decode and the range fold used by the value registers.
package enc_pkg;

   localparam logic [1:0] QS_11 = 2'b11;
   localparam logic [1:0] QS_10 = 2'b10;
   localparam logic [1:0] QS_00 = 2'b00;
   localparam logic [1:0] QS_01 = 2'b01;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_INC  = 2'd1,
      DIR_DEC  = 2'd2
   } dir_t;

   typedef struct packed {
      logic signed [1:0] delta;
      logic              illegal;
   } qdec_t;

   // AB transition: +1 for a clockwise step, -1 counter-clockwise, flag when both bits moved.
   function automatic qdec_t qdec(input logic [1:0] prev, input logic [1:0] cur);
      qdec_t r;
      r.delta   = 2'sb00;
      r.illegal = 1'b0;
      case ({prev, cur})
         {QS_11, QS_10}, {QS_10, QS_00}, {QS_00, QS_01}, {QS_01, QS_11}: r.delta = 2'sb01;
         {QS_11, QS_01}, {QS_01, QS_00}, {QS_00, QS_10}, {QS_10, QS_11}: r.delta = 2'sb11;
         {QS_11, QS_00}, {QS_00, QS_11}, {QS_10, QS_01}, {QS_01, QS_10}: r.illegal = 1'b1;
         default: r.delta = 2'sb00;
      endcase
      return r;
   endfunction

   // Evaluated in 32-bit signed so v +/- step can never overflow before the bound test.
   function automatic int range_fold(input int v, input int step, input dir_t dir,
                                     input int lo, input int hi, input logic wrap);
      int s;
      case (dir)
         DIR_INC: begin
            s = v + step;
            if (s > hi) s = wrap ? lo + (s - hi - 1) : hi;
            else        s = s;
         end
         DIR_DEC: begin
            s = v - step;
            if (s < lo) s = wrap ? hi - (lo - s - 1) : lo;
            else        s = s;
         end
         default: s = v;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: sync + debounce of A/B/button, quadrature decode, step mode and value register.
// Optional fast-turn multiplier when ENC_ACCEL_EN is defined.
module enc_channel
   import enc_pkg::*;
#(
   parameter int CLK_FRE     = 50_000_000,
   parameter int DEBOUNCE_US = 5000,
   parameter int REG_W       = 8,
   parameter int REG_MIN     = 0,
   parameter int REG_MAX     = 255,
   parameter int REG_INIT    = 0,
   parameter int STEP_FINE   = 1,
   parameter int STEP_COARSE = 16,
   parameter int WRAP        = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enc_a,
   input  logic             i_enc_b,
   input  logic             i_enc_btn,
   output logic [REG_W-1:0] o_reg,
   output logic             o_changed,
   output logic             o_btn_pulse,
   output logic             o_coarse
);

   localparam int DEB_CYC = CLK_FRE / 1_000_000 * DEBOUNCE_US;
   localparam int DEB_W   = $clog2(DEB_CYC);

   // bit 0 = A, bit 1 = B, bit 2 = button
   logic [2:0]       sync1_r, sync2_r, deb_r;
   logic [DEB_W-1:0] cnt_r [3];
   logic [1:0]       qs_r;
   logic signed [3:0] acc_r;
   logic [REG_W-1:0] val_r;
   logic             changed_r, btn_prev_r, btn_pulse_r, coarse_r;

   logic [1:0]        cur_s;
   qdec_t             qd_s;
   logic signed [4:0] acc_ext_s;
   logic signed [3:0] acc_sum_s, acc_nx_s;
   dir_t              dir_s;
   logic              btn_fall_s, accel_fast_s;
   int                step_s, val_nx_i;
   logic [REG_W-1:0]  val_nx_s;

   // Two-flop synchronisers and per-bit debounce counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= 3'b111;
         sync2_r <= 3'b111;
         deb_r   <= 3'b111;
         for (int i = 0; i < 3; i++) cnt_r[i] <= '0;
      end else begin
         sync1_r <= {i_enc_btn, i_enc_b, i_enc_a};
         sync2_r <= sync1_r;
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == deb_r[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == DEB_W'(DEB_CYC - 1)) begin
               deb_r[i] <= sync2_r[i];
               cnt_r[i] <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + DEB_W'(1);
            end
         end
      end
   end

   // Quadrature accumulate; a detent request is raised only on arrival at 11 with a full +/-4.
   always_comb begin
      cur_s     = {deb_r[0], deb_r[1]};
      qd_s      = qdec(qs_r, cur_s);
      acc_ext_s = {acc_r[3], acc_r} + {{3{qd_s.delta[1]}}, qd_s.delta};
      if (qd_s.illegal)              acc_sum_s = acc_r;
      else if (acc_ext_s > 5'sd7)    acc_sum_s = 4'sd7;
      else if (acc_ext_s < -5'sd7)   acc_sum_s = -4'sd7;
      else                           acc_sum_s = acc_ext_s[3:0];
      dir_s    = DIR_NONE;
      acc_nx_s = acc_sum_s;
      if ((cur_s == QS_11) && (qs_r != QS_11)) begin
         acc_nx_s = 4'sd0;
         if (acc_sum_s == 4'sd4)       dir_s = DIR_INC;
         else if (acc_sum_s == -4'sd4) dir_s = DIR_DEC;
         else                          dir_s = DIR_NONE;
      end else begin
         acc_nx_s = acc_sum_s;
      end
   end

   assign btn_fall_s = btn_prev_r & ~deb_r[2];

`ifdef ENC_ACCEL_EN
   localparam int ACCEL_CYC = CLK_FRE / 20;
   localparam int ACC_W     = $clog2(ACCEL_CYC + 1);
   logic [ACC_W-1:0] accel_cnt_r;

   // Interval since the last detent; zero means the window has expired.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                accel_cnt_r <= '0;
      else if (dir_s != DIR_NONE)  accel_cnt_r <= ACC_W'(ACCEL_CYC - 1);
      else if (accel_cnt_r != '0)  accel_cnt_r <= accel_cnt_r - ACC_W'(1);
      else                         accel_cnt_r <= accel_cnt_r;
   end

   assign accel_fast_s = (accel_cnt_r != '0);
`else
   assign accel_fast_s = 1'b0;
`endif

   // Step selection uses the mode from before any same-cycle button toggle.
   always_comb begin
      step_s = coarse_r ? STEP_COARSE : STEP_FINE;
      if (accel_fast_s) step_s = step_s * 4;
      else              step_s = step_s;
      val_nx_i = range_fold(int'(val_r), step_s, dir_s, REG_MIN, REG_MAX, WRAP != 0);
      val_nx_s = REG_W'(val_nx_i);
   end

   // Decoder state, value register, button mode and output pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         qs_r        <= QS_11;
         acc_r       <= 4'sd0;
         val_r       <= REG_W'(REG_INIT);
         changed_r   <= 1'b0;
         btn_prev_r  <= 1'b1;
         btn_pulse_r <= 1'b0;
         coarse_r    <= 1'b0;
      end else begin
         qs_r        <= cur_s;
         acc_r       <= acc_nx_s;
         val_r       <= val_nx_s;
         changed_r   <= (dir_s != DIR_NONE) && (val_nx_s != val_r);
         btn_prev_r  <= deb_r[2];
         btn_pulse_r <= btn_fall_s;
         coarse_r    <= coarse_r ^ btn_fall_s;
      end
   end

   assign o_reg       = val_r;
   assign o_changed   = changed_r;
   assign o_btn_pulse = btn_pulse_r;
   assign o_coarse    = coarse_r;

endmodule

// File: rtl/encoder_bank.sv
// NUM_CH independent rotary encoder channels packed onto flat output buses.
// Optional macro ENC_ACCEL_EN enables the per-channel fast-turn step multiplier.
module encoder_bank #(
   parameter int CLK_FRE     = 50_000_000,
   parameter int DEBOUNCE_US = 5000,
   parameter int NUM_CH      = 2,
   parameter int REG_W       = 8,
   parameter int REG_MIN     = 0,
   parameter int REG_MAX     = 255,
   parameter int REG_INIT    = 0,
   parameter int STEP_FINE   = 1,
   parameter int STEP_COARSE = 16,
   parameter int WRAP        = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_CH-1:0]       i_enc_a,
   input  logic [NUM_CH-1:0]       i_enc_b,
   input  logic [NUM_CH-1:0]       i_enc_btn,
   output logic [NUM_CH*REG_W-1:0] o_regs,
   output logic [NUM_CH-1:0]       o_changed,
   output logic [NUM_CH-1:0]       o_btn_pulse,
   output logic [NUM_CH-1:0]       o_coarse
);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      enc_channel #(
         .CLK_FRE     (CLK_FRE),
         .DEBOUNCE_US (DEBOUNCE_US),
         .REG_W       (REG_W),
         .REG_MIN     (REG_MIN),
         .REG_MAX     (REG_MAX),
         .REG_INIT    (REG_INIT),
         .STEP_FINE   (STEP_FINE),
         .STEP_COARSE (STEP_COARSE),
         .WRAP        (WRAP)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_enc_a     (i_enc_a[k]),
         .i_enc_b     (i_enc_b[k]),
         .i_enc_btn   (i_enc_btn[k]),
         .o_reg       (o_regs[k*REG_W +: REG_W]),
         .o_changed   (o_changed[k]),
         .o_btn_pulse (o_btn_pulse[k]),
         .o_coarse    (o_coarse[k])
      );
   end

endmodule
